// File: rtl/ldr_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ldr_wb_pkg
//  Purpose  : Shared types and default widths for the load/store writeback
//             sequencer (FSM states, op classes, width constants).
//  Revision : 1.0 - initial release
// ============================================================================
package ldr_wb_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WB      = 3'd3,
    STORE   = 3'd4,
    NOP     = 3'd5
  } state_t;

  // Instruction class derived from the decode flags
  typedef enum logic [1:0] {
    OP_ALU = 2'd0,
    OP_LDR = 2'd1,
    OP_STR = 2'd2,
    OP_BAD = 2'd3
  } op_t;

  localparam int c_DEF_RAM_LATENCY = 1;
  localparam int c_DEF_ADDR_W      = 32;
  localparam int c_DEF_REG_IDX_W   = 4;
  localparam int c_DATA_W          = 32;
  localparam int c_CNT_W           = 3;   // covers RAM_LATENCY-1 up to 6

  // Both flags set at once is not a real instruction; it becomes a NOP.
  function automatic op_t decode_op(input logic is_ldr, input logic is_str);
    op_t op;
    case ({is_ldr, is_str})
      2'b00:   op = OP_ALU;
      2'b10:   op = OP_LDR;
      2'b01:   op = OP_STR;
      default: op = OP_BAD;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ldr_wb_latency_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : ldr_wb_latency_cnt
//  Purpose  : Loadable down-counter with a zero flag, used to wait out the
//             RAM read latency. Saturates at zero.
//  Revision : 1.0 - initial release
// ============================================================================
module ldr_wb_latency_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] r_count;

  // Load takes priority over decrement; decrement stops at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
  assign done  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ldr_wb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ldr_wb_sequencer
//  Purpose  : Memory-stage / writeback sequencer. Accepts one decoded
//             instruction at a time, issues one-cycle RAM read/write strobes,
//             waits out RAM latency and drives the writeback-mux select plus
//             the register-bank write strobe.
//  Options  : LDR_WB_TRACE_EN - simulation trace of accepts and register
//             writes, plus a check against accepting is_ldr & is_str.
//  Revision : 1.0 - initial release
// ============================================================================
module ldr_wb_sequencer
  import ldr_wb_pkg::*;
#(
  parameter int RAM_LATENCY = c_DEF_RAM_LATENCY,
  parameter int ADDR_W      = c_DEF_ADDR_W,
  parameter int REG_IDX_W   = c_DEF_REG_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 is_ldr,
  input  logic                 is_str,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [c_DATA_W-1:0]  str_data,
  input  logic [REG_IDX_W-1:0] dest_reg,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_rd_en,
  output logic                 ram_wr_en,
  output logic [c_DATA_W-1:0]  ram_wdata,
  output logic                 sel_ldr_mux,
  output logic                 reg_wr_en,
  output logic [REG_IDX_W-1:0] reg_wr_addr,
  output logic                 busy
);

  localparam logic [c_CNT_W-1:0] c_LAT_LOAD = c_CNT_W'(RAM_LATENCY - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  op_t                    w_op;
  logic                   w_accept;
  logic                   w_cnt_load;
  logic                   w_cnt_dec;
  logic                   w_cnt_done;
  logic [c_CNT_W-1:0]     w_cnt_val;
  logic [ADDR_W-1:0]      r_ram_addr;
  logic [c_DATA_W-1:0]    r_ram_wdata;
  logic [REG_IDX_W-1:0]   r_dest;
  logic                   r_sel_ldr;

  assign w_op       = decode_op(is_ldr, is_str);
  assign w_accept   = instr_valid && (r_state == IDLE);
  assign w_cnt_load = w_accept && (w_op == OP_LDR);
  assign w_cnt_dec  = (r_state == RD_REQ) || (r_state == RD_WAIT);

  ldr_wb_latency_cnt #(
    .CNT_W    (c_CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_cnt_load),
    .load_val (c_LAT_LOAD),
    .dec      (w_cnt_dec),
    .count    (w_cnt_val),
    .done     (w_cnt_done)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded strobes
  always_comb begin
    w_state_nxt = r_state;
    instr_ready = 1'b0;
    ram_rd_en   = 1'b0;
    ram_wr_en   = 1'b0;
    reg_wr_en   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (w_accept) begin
          case (w_op)
            OP_ALU:  w_state_nxt = WB;
            OP_LDR:  w_state_nxt = RD_REQ;
            OP_STR:  w_state_nxt = STORE;
            default: w_state_nxt = NOP;
          endcase
        end
      end
      RD_REQ: begin
        ram_rd_en   = 1'b1;
        w_state_nxt = w_cnt_done ? WB : RD_WAIT;
      end
      RD_WAIT: begin
        w_state_nxt = w_cnt_done ? WB : RD_WAIT;
      end
      WB: begin
        reg_wr_en   = 1'b1;
        w_state_nxt = IDLE;
      end
      STORE: begin
        ram_wr_en   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Capture operands on the accepting edge; the mux select is only updated
  // when entering WB so it holds its value in every other state. Entering WB
  // from IDLE means an ALU op, from the read states means a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_dest      <= '0;
      r_sel_ldr   <= 1'b0;
    end else begin
      if (w_accept && ((w_op == OP_LDR) || (w_op == OP_STR))) begin
        r_ram_addr <= mem_addr;
      end
      if (w_accept && (w_op == OP_STR)) begin
        r_ram_wdata <= str_data;
      end
      if (w_accept && ((w_op == OP_LDR) || (w_op == OP_ALU))) begin
        r_dest <= dest_reg;
      end
      if (w_state_nxt == WB) begin
        r_sel_ldr <= (r_state != IDLE);
      end
    end
  end

  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;
  assign reg_wr_addr = r_dest;
  assign sel_ldr_mux = r_sel_ldr;

`ifdef LDR_WB_TRACE_EN
  logic [31:0] r_cycle;

  // Free-running cycle count for trace messages
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  // Trace accepts and register writes; flag accepted illegal flag pairs
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_accept) begin
        $display("[ldr_wb] cyc=%0d accept state=%s op=%s dest=%0d sel=%0b",
                 r_cycle, r_state.name(), w_op.name(), dest_reg, r_sel_ldr);
        assert (!(is_ldr && is_str))
          else $error("[ldr_wb] cyc=%0d is_ldr and is_str accepted together", r_cycle);
      end
      if (reg_wr_en) begin
        $display("[ldr_wb] cyc=%0d reg_wr state=%s dest=%0d sel=%0b",
                 r_cycle, r_state.name(), r_dest, r_sel_ldr);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ldr_wb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ldr_wb_sequencer
//  Purpose  : Directed self-checking bench for ldr_wb_sequencer. One instance
//             with RAM_LATENCY=3 and one with RAM_LATENCY=1 share operand
//             inputs but have separate valid lines.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ldr_wb_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        v3, v1;
  logic        is_ldr, is_str;
  logic [31:0] mem_addr;
  logic [31:0] str_data;
  logic [3:0]  dest_reg;

  logic        d3_ready, d3_rd, d3_wr, d3_sel, d3_reg, d3_busy;
  logic [31:0] d3_addr, d3_wdata;
  logic [3:0]  d3_wa;
  logic        d1_ready, d1_rd, d1_wr, d1_sel, d1_reg, d1_busy;
  logic [31:0] d1_addr, d1_wdata;
  logic [3:0]  d1_wa;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ldr_wb_sequencer #(.RAM_LATENCY(3), .ADDR_W(32), .REG_IDX_W(4)) dut3 (
    .clk(clk), .rst(rst), .instr_valid(v3), .instr_ready(d3_ready),
    .is_ldr(is_ldr), .is_str(is_str), .mem_addr(mem_addr), .str_data(str_data),
    .dest_reg(dest_reg), .ram_addr(d3_addr), .ram_rd_en(d3_rd), .ram_wr_en(d3_wr),
    .ram_wdata(d3_wdata), .sel_ldr_mux(d3_sel), .reg_wr_en(d3_reg),
    .reg_wr_addr(d3_wa), .busy(d3_busy)
  );

  ldr_wb_sequencer #(.RAM_LATENCY(1), .ADDR_W(32), .REG_IDX_W(4)) dut1 (
    .clk(clk), .rst(rst), .instr_valid(v1), .instr_ready(d1_ready),
    .is_ldr(is_ldr), .is_str(is_str), .mem_addr(mem_addr), .str_data(str_data),
    .dest_reg(dest_reg), .ram_addr(d1_addr), .ram_rd_en(d1_rd), .ram_wr_en(d1_wr),
    .ram_wdata(d1_wdata), .sel_ldr_mux(d1_sel), .reg_wr_en(d1_reg),
    .reg_wr_addr(d1_wa), .busy(d1_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
      end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  // Watchdog: the directed sequence is short, so this only fires on a hang
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; v3 = 1'b0; v1 = 1'b0; is_ldr = 1'b0; is_str = 1'b0;
    mem_addr = '0; str_data = '0; dest_reg = '0;

    // ---- reset, then 3 idle cycles
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk1("rst_ready",  d3_ready, 1'b1);
    chk1("rst_rd",     d3_rd,    1'b0);
    chk1("rst_wr",     d3_wr,    1'b0);
    chk1("rst_reg",    d3_reg,   1'b0);
    chk1("rst_busy",   d3_busy,  1'b0);
    chk1("rst_sel",    d3_sel,   1'b0);
    chkw("rst_addr",   d3_addr,  32'h0);
    chkw("rst_wdata",  d3_wdata, 32'h0);
    chk4("rst_wa",     d3_wa,    4'd0);
    chk1("rst_ready1", d1_ready, 1'b1);

    // ---- ALU op, dest 5
    v3 = 1'b1; dest_reg = 4'd5;
    tick();                              // cycle 1
    v3 = 1'b0; dest_reg = 4'd0;
    chk1("alu_reg",   d3_reg,   1'b1);
    chk1("alu_sel",   d3_sel,   1'b0);
    chk4("alu_wa",    d3_wa,    4'd5);
    chk1("alu_ready", d3_ready, 1'b0);
    chk1("alu_busy",  d3_busy,  1'b1);
    chk1("alu_rd",    d3_rd,    1'b0);
    chk1("alu_wr",    d3_wr,    1'b0);
    tick();                              // cycle 2
    chk1("alu_ready2", d3_ready, 1'b1);
    chk1("alu_reg2",   d3_reg,   1'b0);

    // ---- LDR 0x40 -> r3 (latency 3), then an ALU op (r9) held while busy
    v3 = 1'b1; is_ldr = 1'b1; mem_addr = 32'h40; dest_reg = 4'd3;
    tick();                              // cycle 1: RD_REQ
    is_ldr = 1'b0; mem_addr = 32'h99; dest_reg = 4'd9;
    chk1("ldr_rd1",    d3_rd,    1'b1);
    chkw("ldr_addr1",  d3_addr,  32'h40);
    chk1("ldr_wr1",    d3_wr,    1'b0);
    chk1("ldr_reg1",   d3_reg,   1'b0);
    chk1("ldr_ready1", d3_ready, 1'b0);
    tick();                              // cycle 2
    chk1("ldr_rd2",    d3_rd,    1'b0);
    chk1("ldr_reg2",   d3_reg,   1'b0);
    chk1("ldr_busy2",  d3_busy,  1'b1);
    tick();                              // cycle 3
    chk1("ldr_reg3",   d3_reg,   1'b0);
    chk1("ldr_ready3", d3_ready, 1'b0);
    tick();                              // cycle 4: WB
    chk1("ldr_reg4",   d3_reg,   1'b1);
    chk1("ldr_sel4",   d3_sel,   1'b1);
    chk4("ldr_wa4",    d3_wa,    4'd3);
    chk1("ldr_rd4",    d3_rd,    1'b0);
    chk1("ldr_wr4",    d3_wr,    1'b0);
    tick();                              // cycle 5: IDLE, queued ALU accepted at next edge
    chk1("ldr_ready5", d3_ready, 1'b1);
    chk1("ldr_reg5",   d3_reg,   1'b0);
    chk1("ldr_selhold",d3_sel,   1'b1);
    tick();                              // cycle 6: ALU WB
    v3 = 1'b0; dest_reg = 4'd0;
    chk1("q_alu_reg",  d3_reg,   1'b1);
    chk1("q_alu_sel",  d3_sel,   1'b0);
    chk4("q_alu_wa",   d3_wa,    4'd9);
    tick();
    chk1("q_alu_idle", d3_ready, 1'b1);

    // ---- STR 0x10 <- 0xDEADBEEF
    v3 = 1'b1; is_str = 1'b1; mem_addr = 32'h10; str_data = 32'hDEADBEEF;
    tick();                              // cycle 1
    v3 = 1'b0; is_str = 1'b0; mem_addr = '0; str_data = '0;
    chk1("str_wr1",    d3_wr,    1'b1);
    chkw("str_addr1",  d3_addr,  32'h10);
    chkw("str_data1",  d3_wdata, 32'hDEADBEEF);
    chk1("str_reg1",   d3_reg,   1'b0);
    chk1("str_rd1",    d3_rd,    1'b0);
    tick();                              // cycle 2
    chk1("str_wr2",    d3_wr,    1'b0);
    chk1("str_reg2",   d3_reg,   1'b0);
    chk1("str_ready2", d3_ready, 1'b1);

    // ---- illegal flags -> NOP
    v3 = 1'b1; is_ldr = 1'b1; is_str = 1'b1; dest_reg = 4'd7;
    tick();                              // cycle 1
    v3 = 1'b0; is_ldr = 1'b0; is_str = 1'b0; dest_reg = 4'd0;
    chk1("bad_busy1",  d3_busy,  1'b1);
    chk1("bad_ready1", d3_ready, 1'b0);
    chk1("bad_rd1",    d3_rd,    1'b0);
    chk1("bad_wr1",    d3_wr,    1'b0);
    chk1("bad_reg1",   d3_reg,   1'b0);
    tick();                              // cycle 2
    chk1("bad_ready2", d3_ready, 1'b1);
    chk1("bad_busy2",  d3_busy,  1'b0);
    chk1("bad_reg2",   d3_reg,   1'b0);

    // ---- reset during RD_WAIT discards the load
    v3 = 1'b1; is_ldr = 1'b1; mem_addr = 32'h44; dest_reg = 4'd8;
    tick();                              // cycle 1: RD_REQ
    v3 = 1'b0; is_ldr = 1'b0; mem_addr = '0; dest_reg = 4'd0;
    chk1("rl_rd1",     d3_rd,    1'b1);
    tick();                              // cycle 2: RD_WAIT
    chk1("rl_busy2",   d3_busy,  1'b1);
    chk1("rl_rd2",     d3_rd,    1'b0);
    rst = 1'b1;
    tick();
    chk1("rl_ready",   d3_ready, 1'b1);
    chk1("rl_busy",    d3_busy,  1'b0);
    chk1("rl_reg",     d3_reg,   1'b0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1("rl_noreg",  d3_reg,   1'b0);
    end

    // ---- latency 1, valid held high, alternating LDR / ALU
    v1 = 1'b1; is_ldr = 1'b1; mem_addr = 32'h20; dest_reg = 4'd1;
    tick();                              // c1: RD_REQ
    is_ldr = 1'b0; dest_reg = 4'd2;
    chk1("b2b_rd1",    d1_rd,    1'b1);
    chkw("b2b_addr1",  d1_addr,  32'h20);
    chk1("b2b_ready1", d1_ready, 1'b0);
    tick();                              // c2: WB (LDR r1)
    chk1("b2b_reg2",   d1_reg,   1'b1);
    chk1("b2b_sel2",   d1_sel,   1'b1);
    chk4("b2b_wa2",    d1_wa,    4'd1);
    tick();                              // c3: IDLE
    chk1("b2b_ready3", d1_ready, 1'b1);
    chk1("b2b_reg3",   d1_reg,   1'b0);
    tick();                              // c4: WB (ALU r2)
    is_ldr = 1'b1; mem_addr = 32'h80; dest_reg = 4'd4;
    chk1("b2b_reg4",   d1_reg,   1'b1);
    chk1("b2b_sel4",   d1_sel,   1'b0);
    chk4("b2b_wa4",    d1_wa,    4'd2);
    tick();                              // c5: IDLE
    chk1("b2b_ready5", d1_ready, 1'b1);
    chk1("b2b_reg5",   d1_reg,   1'b0);
    tick();                              // c6: RD_REQ
    is_ldr = 1'b0; dest_reg = 4'd6;
    chk1("b2b_rd6",    d1_rd,    1'b1);
    chkw("b2b_addr6",  d1_addr,  32'h80);
    tick();                              // c7: WB (LDR r4)
    chk1("b2b_reg7",   d1_reg,   1'b1);
    chk1("b2b_sel7",   d1_sel,   1'b1);
    chk4("b2b_wa7",    d1_wa,    4'd4);
    tick();                              // c8: IDLE
    chk1("b2b_ready8", d1_ready, 1'b1);
    tick();                              // c9: WB (ALU r6)
    v1 = 1'b0; dest_reg = 4'd0;
    chk1("b2b_reg9",   d1_reg,   1'b1);
    chk1("b2b_sel9",   d1_sel,   1'b0);
    chk4("b2b_wa9",    d1_wa,    4'd6);
    tick();                              // c10: IDLE, nothing pending
    chk1("b2b_ready10", d1_ready, 1'b1);
    chk1("b2b_reg10",   d1_reg,   1'b0);
    chk1("b2b_wr_none", d1_wr,    1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
